// File: rtl/pipelined_mask_shifter.sv
// pipelined_mask_shifter: two-stage barrel shifter built around a thermometer keep-mask.
// Supported ops: logical left, logical right, arithmetic right and rotate right of a
// WIDTH-bit word.
//   Stage 1 rotates the operand and decodes the keep-mask, the fill word and the carry.
//   Stage 2 merges the rotated word with the fill and registers the results.
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_ready depends combinationally on out_ready
//   in_data, in_amt, in_op     operand, shift amount 0..WIDTH-1, op (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   out_valid/out_ready        result handshake
//   out_data, out_mask         shifted word; keep-mask used to build it
//   out_carry, out_zero        last bit shifted out; result-is-zero flag
module pipelined_mask_shifter #(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_mask,
   output logic             out_carry,
   output logic             out_zero
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   logic               s1_valid;
   logic               s2_valid;
   logic               s1_load;
   logic               s2_load;
   logic [WIDTH-1:0]   s1_rot;
   logic [WIDTH-1:0]   s1_mask;
   logic [WIDTH-1:0]   s1_fill;
   logic               s1_carry;

   logic [2*WIDTH-1:0] dbl_l_c;
   logic [2*WIDTH-1:0] dbl_r_c;
   logic [SHW-1:0]     up_idx_c;
   logic [SHW-1:0]     dn_idx_c;
   logic [WIDTH-1:0]   rot_c;
   logic [WIDTH-1:0]   mask_c;
   logic [WIDTH-1:0]   fill_c;
   logic               carry_c;
   logic [WIDTH-1:0]   merged_c;

   // Flow control: each stage may load when it is empty or its successor drains.
   assign s2_load   = !s2_valid || out_ready;
   assign s1_load   = !s1_valid || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;

   // Stage 1 decode: rotate, thermometer mask, sign fill, shifted-out bit.
   always_comb begin
      // Rotation is a shift of the doubled word. The left-rotate result sits in the upper half.
      dbl_l_c  = {in_data, in_data} << in_amt;
      dbl_r_c  = {in_data, in_data} >> in_amt;
      // WIDTH is a power of two, so these wrap to WIDTH-amt and amt-1.
      up_idx_c = SHW'(0) - in_amt;
      dn_idx_c = in_amt - SHW'(1);
      rot_c    = dbl_r_c[WIDTH-1:0];
      mask_c   = {WIDTH{1'b1}};
      fill_c   = '0;
      carry_c  = 1'b0;
      case (in_op)
         OP_SLL: begin
            rot_c  = dbl_l_c[2*WIDTH-1:WIDTH];
            mask_c = {WIDTH{1'b1}} << in_amt;
            if (in_amt != '0) carry_c = in_data[up_idx_c];
         end
         OP_SRL: begin
            mask_c = {WIDTH{1'b1}} >> in_amt;
            if (in_amt != '0) carry_c = in_data[dn_idx_c];
         end
         OP_SRA: begin
            mask_c = {WIDTH{1'b1}} >> in_amt;
            fill_c = {WIDTH{in_data[WIDTH-1]}};
            if (in_amt != '0) carry_c = in_data[dn_idx_c];
         end
         default: begin
            if (in_amt != '0) carry_c = in_data[dn_idx_c];
         end
      endcase
   end

   // Stage 2 merge: kept bits come from the rotated word, the rest from the fill.
   always_comb begin
      merged_c = (s1_rot & s1_mask) | (s1_fill & ~s1_mask);
   end

   // Stage 1 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_rot   <= '0;
         s1_mask  <= '0;
         s1_fill  <= '0;
         s1_carry <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_rot   <= rot_c;
            s1_mask  <= mask_c;
            s1_fill  <= fill_c;
            s1_carry <= carry_c;
         end
      end
   end

   // Stage 2 / output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         out_carry <= 1'b0;
         out_zero  <= 1'b0;
      end else if (s2_load) begin
         s2_valid  <= s1_valid;
         out_data  <= merged_c;
         out_mask  <= s1_mask;
         out_carry <= s1_carry;
         out_zero  <= (merged_c == '0);
      end
   end

endmodule

// File: tb/tb_pipelined_mask_shifter.sv
// tb_pipelined_mask_shifter: WIDTH=8 bench for pipelined_mask_shifter.
// Contents:
//   - Directed vectors with known answers.
//   - A streaming and stall sequence.
//   - Reset while items are in flight.
//   - Random traffic checked against an arithmetic reference model through an in-order scoreboard.
module tb_pipelined_mask_shifter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [2:0]   in_amt;
   logic [1:0]   in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [W-1:0] out_mask;
   logic         out_carry;
   logic         out_zero;

   int n_chk = 0;
   int n_err = 0;
   int n_acc = 0;
   logic        mon_en = 1'b0;
   logic        held   = 1'b0;
   logic [17:0] held_v = '0;
   logic [17:0] sb[$];

   pipelined_mask_shifter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_carry (out_carry),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: shifts expressed as multiply/divide by powers of two on integers.
   function automatic logic [17:0] model(input logic [1:0] op, input int amt, input int d);
      int p;
      int r;
      int m;
      int c;
      p = 1 << amt;
      c = (amt == 0) ? 0 : (d / (p / 2)) % 2;
      case (op)
         2'd0: begin
            r = (d * p) % 256;
            m = 256 - p;
            c = (amt == 0) ? 0 : (d / (256 / p)) % 2;
         end
         2'd1: begin
            r = d / p;
            m = 256 / p - 1;
         end
         2'd2: begin
            r = d / p + ((d >= 128) ? 256 - 256 / p : 0);
            m = 256 / p - 1;
         end
         default: begin
            r = d / p + (d % p) * (256 / p);
            m = 255;
         end
      endcase
      return {8'(r), 8'(m), 1'(c), (r == 0)};
   endfunction

   // Scoreboard monitor, sampling 2 time units after the falling edge.
   always @(negedge clk) begin
      #2;
      if (!rst_n || !mon_en) begin
         if (!rst_n) sb.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'({out_data, out_mask, out_carry, out_zero}), 32'(held_v));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
            else check("result", 32'({out_data, out_mask, out_carry, out_zero}), 32'(sb.pop_front()));
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(in_op, int'(in_amt), int'(in_data)));
            n_acc++;
         end
         held   = out_valid && !out_ready;
         held_v = {out_data, out_mask, out_carry, out_zero};
      end
   end

   // Single item into an idle pipeline: latency and known answer.
   task automatic run_vec(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] d,
                          input logic [7:0] ed, input logic [7:0] em, input logic ec, input logic ez);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_amt = amt; in_data = d; out_ready = 1'b1;
      #2 check("dir_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 check("dir_lat_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      #2;
      check("dir_valid", 32'(out_valid), 32'd1);
      check("dir_data", 32'(out_data), 32'(ed));
      check("dir_mask", 32'(out_mask), 32'(em));
      check("dir_carry", 32'(out_carry), 32'(ec));
      check("dir_zero", 32'(out_zero), 32'(ez));
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
      #3;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_mask", 32'(out_mask), 32'd0);
      check("rst_carry", 32'(out_carry), 32'd0);
      check("rst_zero", 32'(out_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed known-answer vectors
      run_vec(2'd2, 3'd3, 8'h96, 8'hF2, 8'h1F, 1'b1, 1'b0);
      run_vec(2'd0, 3'd1, 8'h81, 8'h02, 8'hFE, 1'b1, 1'b0);
      run_vec(2'd3, 3'd1, 8'h01, 8'h80, 8'hFF, 1'b1, 1'b0);
      run_vec(2'd1, 3'd7, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0);
      for (int op = 0; op < 4; op++) run_vec(2'(op), 3'd0, 8'hA5, 8'hA5, 8'hFF, 1'b0, 1'b0);
      run_vec(2'd1, 3'd4, 8'h0F, 8'h00, 8'h0F, 1'b1, 1'b1);
      run_vec(2'd2, 3'd7, 8'h80, 8'hFF, 8'h01, 1'b0, 1'b0);
      run_vec(2'd0, 3'd7, 8'h03, 8'h80, 8'h80, 1'b1, 1'b0);

      // Stream 8 items at full rate, then stall for 3 cycles
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         in_valid = 1'b1; in_op = 2'(k); in_amt = 3'(k); in_data = 8'($urandom); out_ready = 1'b1;
         #2;
         check("stream_in_ready", 32'(in_ready), 32'd1);
         if (k >= 2) check("stream_rate", 32'(out_valid), 32'd1);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = 2'(k); in_amt = 3'(k + 2); in_data = 8'($urandom); out_ready = 1'b0;
         #2;
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end

      // Reset with both stages occupied
      @(negedge clk);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'({out_data, out_mask, out_carry, out_zero}), 32'd0);
      @(negedge clk);
      #4 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #2 check("no_stale", 32'(out_valid), 32'd0);
      end

      // Random traffic against the reference model
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         @(negedge clk);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         in_op     = 2'($urandom);
         in_amt    = 3'($urandom);
         in_data   = 8'($urandom);
         cyc++;
      end
      check("random_accepts", 32'(n_acc >= 10000), 32'd1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (sb.size() != 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      @(negedge clk);
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
